// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph table, blank pattern, decoder
// and scanner FSM encodings. The display driver imports this package too,
// so the encoder and the decoder read one table.
package seg_pkg;

  // Active-low segment patterns, bits [6:0] = g..a, indexed by hex value.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // All segments off. This is not a glyph, so it decodes as illegal.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scanner FSM encodings.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } seg_dec_t;

  // Reverse lookup of a segment pattern. Unknown patterns return legal=0.
  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t r;
    r.legal  = 1'b0;
    r.nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_GLYPH[i]) begin
        r.legal  = 1'b1;
        r.nibble = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_settle_cnt.sv
// seg_settle_cnt: compares the registered scan bus against its value one
// cycle earlier and counts consecutive stable cycles while enabled.
// The counter saturates and never wraps.
module seg_settle_cnt
  import seg_pkg::*;
#(
  parameter int N_DIGITS      = 3,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [6:0]          seg_i,
  input  logic [N_DIGITS-1:0] an_i,
  output logic                stable_o,
  output logic                settled_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [6:0]          seg_prev_q;
  logic [N_DIGITS-1:0] an_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // A simultaneous segment and anode change is a single instability.
  assign stable_o  = (seg_i == seg_prev_q) && (an_i == an_prev_q);
  assign settled_o = en_i && stable_o && (cnt_q == CNT_LAST);

  // Count stable cycles while enabled; any change or disable restarts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || !stable_o) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Previous-cycle copy of the bus and the stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_prev_q <= SEG_BLANK;
      an_prev_q  <= '1;
      cnt_q      <= '0;
    end else begin
      seg_prev_q <= seg_i;
      an_prev_q  <= an_i;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads the multiplexed seven-segment scan bus back,
// waits for each slot to settle, decodes the glyph into a per-digit nibble
// and reports captures, illegal glyphs and completed frames as pulses.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int N_DIGITS      = 3,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  btnC,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  updated,
  output logic                  bad_pattern,
  output logic                  frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [6:0]            seg_q;
  logic [N_DIGITS-1:0]   an_q;
  logic [1:0]            state_q, state_d;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d, seen_nxt;
  logic                  upd_q, upd_d, bad_q, bad_d, frm_q, frm_d;
  logic                  stable, settled, slot_legal, capture;
  logic [IDX_W-1:0]      idx;
  seg_dec_t              dec;

  seg_settle_cnt #(
    .N_DIGITS      (N_DIGITS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk       (clk),
    .rst       (btnC),
    .en_i      (state_q == ST_SETTLE),
    .seg_i     (seg_q),
    .an_i      (an_q),
    .stable_o  (stable),
    .settled_o (settled)
  );

  // Slot is legal with exactly one anode low; idx is that anode's position.
  always_comb begin
    slot_legal = ($countones(~an_q) == 1);
    idx        = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!an_q[i]) idx = IDX_W'(i);
    end
  end

  assign dec     = seg_decode(seg_q);
  assign capture = (state_q == ST_SETTLE) && settled && slot_legal;

  // Scanner FSM plus the capture write into the digit, valid and seen state.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    seen_nxt = seen_q;
    upd_d    = 1'b0;
    bad_d    = 1'b0;
    frm_d    = 1'b0;
    case (state_q)
      ST_IDLE:    if (slot_legal) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!stable && !slot_legal) state_d = ST_IDLE;
        else if (capture)           state_d = ST_CAPTURE;
      end
      // A change landing in the capture cycle must not be lost, so it is
      // handled exactly like a change seen while holding.
      ST_CAPTURE: begin
        if (!stable) state_d = slot_legal ? ST_SETTLE : ST_IDLE;
        else         state_d = ST_HOLD;
      end
      ST_HOLD:    if (!stable) state_d = slot_legal ? ST_SETTLE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Outputs are written on the edge entering CAPTURE so the pulses are
    // visible during the CAPTURE cycle itself.
    if (capture) begin
      upd_d         = 1'b1;
      seen_nxt[idx] = 1'b1;
      if (dec.legal) begin
        digits_d[4*idx +: 4] = dec.nibble;
        valid_d[idx]         = 1'b1;
      end else begin
        valid_d[idx] = 1'b0;
        bad_d        = 1'b1;
      end
      if (&seen_nxt) begin
        frm_d  = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_nxt;
      end
    end
  end

  // Input registers, FSM state and registered outputs.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
      state_q  <= ST_IDLE;
      digits_q <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      upd_q    <= 1'b0;
      bad_q    <= 1'b0;
      frm_q    <= 1'b0;
    end else begin
      seg_q    <= seg_in;
      an_q     <= an_in;
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      upd_q    <= upd_d;
      bad_q    <= bad_d;
      frm_q    <= frm_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign updated     = upd_q;
  assign bad_pattern = bad_q;
  assign frame_done  = frm_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE_CYCLES=4, N_DIGITS=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg_scan_decoder;

  localparam logic [6:0] G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000, G8 = 7'b0000000, G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000, GB = 7'b0000011, GF = 7'b0001110;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        btnC = 1'b1;
  logic [6:0]  seg_in = BLANK;
  logic [2:0]  an_in = 3'b111;
  logic [11:0] digits;
  logic [2:0]  digit_valid;
  logic        updated, bad_pattern, frame_done;

  int n_cmp = 0, n_fail = 0;
  int n_upd, n_bad, n_frm, upd_first, frm_upd_idx, frm_alone;

  seg_scan_decoder #(.N_DIGITS(3), .SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .btnC        (btnC),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits      (digits),
    .digit_valid (digit_valid),
    .updated     (updated),
    .bad_pattern (bad_pattern),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic clr_counts();
    n_upd = 0; n_bad = 0; n_frm = 0; upd_first = 0; frm_upd_idx = 0; frm_alone = 0;
  endtask

  // Advance n falling edges, tallying output pulses seen at each one.
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (updated) begin
        n_upd++;
        if (upd_first == 0) upd_first = i;
      end
      if (bad_pattern) n_bad++;
      if (frame_done) begin
        n_frm++;
        frm_upd_idx = n_upd;
        if (!updated) frm_alone++;
      end
    end
  endtask

  task automatic drive(input logic [2:0] an, input logic [6:0] seg);
    an_in = an;
    seg_in = seg;
  endtask

  task automatic do_reset();
    btnC = 1'b1;
    drive(3'b111, BLANK);
    run(2);
    btnC = 1'b0;
    run(2);
  endtask

  task automatic test_reset();
    drive(3'b110, G8);
    run(2);
    n_cmp++; if (digits !== 12'h000) begin n_fail++; $display("FAIL rst_digits got %h want %h", digits, 12'h000); end
    n_cmp++; if (digit_valid !== 3'b000) begin n_fail++; $display("FAIL rst_valid got %b want %b", digit_valid, 3'b000); end
    n_cmp++; if ({updated, bad_pattern, frame_done} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses got %b want 000", {updated, bad_pattern, frame_done}); end
    drive(3'b111, BLANK);
    btnC = 1'b0;
    run(3);
    clr_counts();
    drive(3'b110, G1);
    run(8);
    n_cmp++; if (upd_first !== 6) begin n_fail++; $display("FAIL first_latency got %0d want %0d", upd_first, 6); end
    n_cmp++; if (n_upd !== 1) begin n_fail++; $display("FAIL first_upd_count got %0d want %0d", n_upd, 1); end
    n_cmp++; if (digits[3:0] !== 4'h1) begin n_fail++; $display("FAIL first_digit0 got %h want %h", digits[3:0], 4'h1); end
    n_cmp++; if (digit_valid !== 3'b001) begin n_fail++; $display("FAIL first_valid got %b want %b", digit_valid, 3'b001); end
  endtask

  task automatic test_full_frame();
    do_reset();
    clr_counts();
    drive(3'b110, G3); run(8);
    drive(3'b101, GA); run(8);
    drive(3'b011, GF); run(8);
    n_cmp++; if (n_upd !== 3) begin n_fail++; $display("FAIL frame_upd_count got %0d want %0d", n_upd, 3); end
    n_cmp++; if (digits !== 12'hFA3) begin n_fail++; $display("FAIL frame_digits got %h want %h", digits, 12'hFA3); end
    n_cmp++; if (digit_valid !== 3'b111) begin n_fail++; $display("FAIL frame_valid got %b want %b", digit_valid, 3'b111); end
    n_cmp++; if (n_frm !== 1) begin n_fail++; $display("FAIL frame_done_count got %0d want %0d", n_frm, 1); end
    n_cmp++; if (frm_upd_idx !== 3) begin n_fail++; $display("FAIL frame_done_at_upd got %0d want %0d", frm_upd_idx, 3); end
    n_cmp++; if (frm_alone !== 0) begin n_fail++; $display("FAIL frame_without_upd got %0d want %0d", frm_alone, 0); end
    n_cmp++; if (n_bad !== 0) begin n_fail++; $display("FAIL frame_bad got %0d want %0d", n_bad, 0); end
  endtask

  task automatic test_bounce();
    clr_counts();
    for (int j = 0; j < 10; j++) begin
      drive(3'b110, (j % 2) ? G2 : G7);
      run(2);
    end
    n_cmp++; if (n_upd !== 0) begin n_fail++; $display("FAIL bounce_no_upd got %0d want %0d", n_upd, 0); end
    run(10);
    n_cmp++; if (n_upd !== 1) begin n_fail++; $display("FAIL bounce_one_upd got %0d want %0d", n_upd, 1); end
    n_cmp++; if (digits[3:0] !== 4'h2) begin n_fail++; $display("FAIL bounce_value got %h want %h", digits[3:0], 4'h2); end
  endtask

  task automatic test_illegal_glyph();
    clr_counts();
    drive(3'b101, G5); run(8);
    n_cmp++; if (digits[7:4] !== 4'h5) begin n_fail++; $display("FAIL glyph5_value got %h want %h", digits[7:4], 4'h5); end
    n_cmp++; if (digit_valid[1] !== 1'b1) begin n_fail++; $display("FAIL glyph5_valid got %b want %b", digit_valid[1], 1'b1); end
    clr_counts();
    drive(3'b101, BLANK); run(8);
    n_cmp++; if (n_bad !== 1) begin n_fail++; $display("FAIL bad_count got %0d want %0d", n_bad, 1); end
    n_cmp++; if (n_upd !== 1) begin n_fail++; $display("FAIL bad_upd_count got %0d want %0d", n_upd, 1); end
    n_cmp++; if (digit_valid[1] !== 1'b0) begin n_fail++; $display("FAIL bad_valid got %b want %b", digit_valid[1], 1'b0); end
    n_cmp++; if (digits[7:4] !== 4'h5) begin n_fail++; $display("FAIL bad_retained got %h want %h", digits[7:4], 4'h5); end
    n_cmp++; if (n_frm !== 0) begin n_fail++; $display("FAIL bad_no_frame got %0d want %0d", n_frm, 0); end
  endtask

  task automatic test_illegal_anodes();
    do_reset();
    clr_counts();
    drive(3'b100, G8); run(50);
    drive(3'b111, G8); run(50);
    n_cmp++; if (n_upd + n_bad + n_frm !== 0) begin n_fail++; $display("FAIL anode_pulses got %0d want %0d", n_upd + n_bad + n_frm, 0); end
    n_cmp++; if (digit_valid !== 3'b000) begin n_fail++; $display("FAIL anode_valid got %b want %b", digit_valid, 3'b000); end
    clr_counts();
    drive(3'b110, G8); run(8);
    n_cmp++; if (upd_first !== 6) begin n_fail++; $display("FAIL anode_recover_latency got %0d want %0d", upd_first, 6); end
    n_cmp++; if (digits[3:0] !== 4'h8) begin n_fail++; $display("FAIL anode_recover_value got %h want %h", digits[3:0], 4'h8); end
  endtask

  task automatic test_reset_mid();
    clr_counts();
    drive(3'b011, G6);
    run(4);
    btnC = 1'b1;
    #1;
    n_cmp++; if (digits !== 12'h000) begin n_fail++; $display("FAIL midrst_digits got %h want %h", digits, 12'h000); end
    n_cmp++; if (digit_valid !== 3'b000) begin n_fail++; $display("FAIL midrst_valid got %b want %b", digit_valid, 3'b000); end
    run(2);
    btnC = 1'b0;
    clr_counts();
    run(8);
    n_cmp++; if (upd_first !== 6) begin n_fail++; $display("FAIL midrst_latency got %0d want %0d", upd_first, 6); end
    n_cmp++; if (n_upd !== 1) begin n_fail++; $display("FAIL midrst_upd_count got %0d want %0d", n_upd, 1); end
    n_cmp++; if (digits !== 12'h600) begin n_fail++; $display("FAIL midrst_digits_after got %h want %h", digits, 12'h600); end
    n_cmp++; if (digit_valid !== 3'b100) begin n_fail++; $display("FAIL midrst_valid_after got %b want %b", digit_valid, 3'b100); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clr_counts();
    drive(3'b110, G1); run(8);
    drive(3'b110, G4); run(8);
    drive(3'b101, G9); run(8);
    drive(3'b011, GB); run(8);
    n_cmp++; if (n_upd !== 4) begin n_fail++; $display("FAIL b2b_upd_count got %0d want %0d", n_upd, 4); end
    n_cmp++; if (n_frm !== 1) begin n_fail++; $display("FAIL b2b_frame_count got %0d want %0d", n_frm, 1); end
    n_cmp++; if (frm_upd_idx !== 4) begin n_fail++; $display("FAIL b2b_frame_at_upd got %0d want %0d", frm_upd_idx, 4); end
    n_cmp++; if (digits !== 12'hB94) begin n_fail++; $display("FAIL b2b_digits got %h want %h", digits, 12'hB94); end
    n_cmp++; if (digit_valid !== 3'b111) begin n_fail++; $display("FAIL b2b_valid got %b want %b", digit_valid, 3'b111); end
  endtask

  initial begin
    clr_counts();
    test_reset();
    test_full_frame();
    test_bounce();
    test_illegal_glyph();
    test_illegal_anodes();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
